// File: rtl/key_device_if.sv
`default_nettype none
// =============================================================================
// Interface : key_device_if
// Brief     : Address and write-strobe half of the shared processor bus.
//             DBUS stays a module port because it is bidirectional.
// Revision  : 1.0
// =============================================================================
interface key_device_if #(
   parameter int BITS = 32
);
   logic [BITS-1:0] ABUS;
   logic            WE;

   modport master (output ABUS, output WE);
   modport slave  (input  ABUS, input  WE);
endinterface
`default_nettype wire

// File: rtl/key_device.sv
`default_nettype none
// =============================================================================
// Module    : key_device
// Brief     : Memory-mapped debounced pushbutton input with KDATA/KCTRL
//             registers and a level interrupt. Macro KEY_DEBOUNCE_EN enables
//             the per-key debounce counters.
// Revision  : 1.0
// =============================================================================
module key_device #(
   parameter int          BITS     = 32,
   parameter logic [31:0] BASE     = 32'hF0000010,
   parameter logic [15:0] DEBOUNCE = 16'd50000
) (
   input  wire              CLK,
   input  wire              reset,
   key_device_if.slave      bus,
   inout  wire  [BITS-1:0]  DBUS,
   input  wire  [3:0]       KEY,
   output logic             INTR
);

   localparam logic [BITS-1:0] c_ADDR_DATA = BITS'(BASE);
   localparam logic [BITS-1:0] c_ADDR_CTRL = BITS'(BASE + 32'd4);

   logic [3:0]      r_s1;
   logic [3:0]      r_s2;
   logic [3:0]      r_stb;
   logic            r_ready;
   logic            r_overrun;
   logic            r_ie;

   logic [3:0]      w_stb_nxt;
   logic            w_chg;
   logic            w_sel_data;
   logic            w_sel_ctrl;
   logic            w_rd_data;
   logic            w_rd_ctrl;
   logic            w_wr_ctrl;
   logic            w_ready_nxt;
   logic            w_overrun_nxt;
   logic            w_ie_nxt;
   logic [BITS-1:0] w_rdata;
   logic            w_unused;

`ifdef KEY_DEBOUNCE_EN
   localparam int                 c_CNT_W   = $clog2(DEBOUNCE) + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE - 16'd1);

   logic [c_CNT_W-1:0] r_cnt     [4];
   logic [c_CNT_W-1:0] w_cnt_nxt [4];

   // A key is accepted only after DEBOUNCE consecutive mismatching samples.
   always_comb begin
      w_stb_nxt = r_stb;
      for (int i = 0; i < 4; i++) begin
         w_cnt_nxt[i] = r_cnt[i] + c_CNT_W'(1);
         if (r_s2[i] == r_stb[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (r_cnt[i] == c_CNT_MAX) begin
            w_stb_nxt[i] = r_s2[i];
            w_cnt_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) r_cnt[i] <= '0;
         else       r_cnt[i] <= w_cnt_nxt[i];
      end
   end

   assign w_unused = ^{DBUS[BITS-1:9], DBUS[7:2], DBUS[0]};
`else
   assign w_stb_nxt = r_s2;
   assign w_unused  = ^{DBUS[BITS-1:9], DBUS[7:2], DBUS[0], DEBOUNCE};
`endif

   assign w_chg      = |(w_stb_nxt ^ r_stb);
   assign w_sel_data = (bus.ABUS == c_ADDR_DATA);
   assign w_sel_ctrl = (bus.ABUS == c_ADDR_CTRL);
   assign w_rd_data  = !bus.WE && w_sel_data;
   assign w_rd_ctrl  = !bus.WE && w_sel_ctrl;
   assign w_wr_ctrl  = bus.WE && w_sel_ctrl;

   // A new event beats a concurrent KDATA read; a concurrent read suppresses overrun.
   assign w_ready_nxt   = w_chg | (r_ready & ~w_rd_data);
   assign w_overrun_nxt = (w_chg & r_ready & ~w_rd_data)
                        | (r_overrun & ~(w_wr_ctrl & ~DBUS[1]));
   assign w_ie_nxt      = w_wr_ctrl ? DBUS[8] : r_ie;

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_s1      <= 4'hF;
         r_s2      <= 4'hF;
         r_stb     <= 4'hF;
         r_ready   <= 1'b0;
         r_overrun <= 1'b0;
         r_ie      <= 1'b0;
         INTR      <= 1'b0;
      end else begin
         r_s1      <= KEY;
         r_s2      <= r_s1;
         r_stb     <= w_stb_nxt;
         r_ready   <= w_ready_nxt;
         r_overrun <= w_overrun_nxt;
         r_ie      <= w_ie_nxt;
         INTR      <= w_ie_nxt & w_ready_nxt;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_sel_data) begin
         w_rdata[3:0] = ~r_stb;
      end else begin
         w_rdata[0] = r_ready;
         w_rdata[1] = r_overrun;
         w_rdata[8] = r_ie;
      end
   end

   assign DBUS = (w_rd_data || w_rd_ctrl) ? w_rdata : {BITS{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_key_device.sv
`default_nettype none
// Testbench for key_device: directed scenarios plus a randomized phase checked
// against a sample-history reference model.
module tb_key_device;
   localparam int          BITS = 32;
   localparam logic [31:0] BASE = 32'hF0000010;
   localparam logic [31:0] CTRL = BASE + 32'd4;
`ifdef KEY_DEBOUNCE_EN
   localparam int D = 4;
`else
   localparam int D = 1;
`endif
   localparam int LAT = D + 2;

   logic        CLK  = 1'b0;
   logic        rst  = 1'b1;
   logic [3:0]  key  = 4'hF;
   logic        drv  = 1'b0;
   logic [31:0] wdat = '0;
   wire  [31:0] DBUS;
   wire         INTR;

   int checks = 0;
   int errors = 0;

   assign DBUS = drv ? wdat : 'z;

   key_device_if #(.BITS(BITS)) bus ();

   key_device #(.BITS(BITS), .BASE(BASE), .DEBOUNCE(16'd4)) dut (
      .CLK   (CLK),
      .reset (rst),
      .bus   (bus),
      .DBUS  (DBUS),
      .KEY   (key),
      .INTR  (INTR)
   );

   always #5 CLK = ~CLK;

   // Reference model: a key's accepted level flips once the last D synchronised
   // samples (raw samples two edges old) all disagree with it.
   logic [3:0] m_stb;
   logic       m_ready, m_ov, m_ie, m_intr;
   logic [3:0] hist[$];

   function automatic void m_reset();
      m_stb = 4'hF; m_ready = 0; m_ov = 0; m_ie = 0; m_intr = 0;
      hist.delete();
      for (int j = 0; j < D + 2; j++) hist.push_back(4'hF);
   endfunction

   function automatic void m_step(input logic [3:0] k, input logic [31:0] a,
                                  input logic we, input logic [31:0] d);
      logic [3:0] nstb;
      logic [3:0] e;
      logic       all_diff, rdd, wrc, chg;
      rdd = !we && (a == BASE);
      wrc = we && (a == CTRL);
      hist.push_front(k);
      void'(hist.pop_back());
      nstb = m_stb;
      for (int i = 0; i < 4; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) begin
            e = hist[2 + j];
            if (e[i] == m_stb[i]) all_diff = 1'b0;
         end
         if (all_diff) nstb[i] = ~m_stb[i];
      end
      chg = (nstb != m_stb);
      if (chg && m_ready && !rdd) m_ov = 1'b1;
      else if (wrc && !d[1])      m_ov = 1'b0;
      if (chg)      m_ready = 1'b1;
      else if (rdd) m_ready = 1'b0;
      if (wrc) m_ie = d[8];
      m_intr = m_ie & m_ready;
      m_stb  = nstb;
   endfunction

   function automatic logic [31:0] exp_reg(input logic [31:0] a);
      if (a == BASE) return {28'b0, ~m_stb};
      return {23'b0, m_ie, 6'b0, m_ov, m_ready};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic        p_rst, p_we;
      logic [3:0]  p_key;
      logic [31:0] p_a, p_d;
      p_rst = rst; p_key = key; p_a = bus.ABUS; p_we = bus.WE; p_d = wdat;
      @(posedge CLK);
      if (p_rst) m_reset();
      else       m_step(p_key, p_a, p_we, p_d);
      #1;
      chk("intr", {31'b0, INTR}, {31'b0, m_intr});
   endtask

   task automatic idle();
      bus.ABUS = 32'h0; bus.WE = 1'b0; drv = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Bus read: checks against the model and optionally a fixed expected value.
   task automatic rd(input string tag, input logic [31:0] a,
                     input logic use_k, input logic [31:0] kval);
      bus.ABUS = a; bus.WE = 1'b0; drv = 1'b0;
      #1;
      chk(tag, DBUS, exp_reg(a));
      if (use_k) chk({tag, "_k"}, DBUS, kval);
      tick();
      idle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.ABUS = a; bus.WE = 1'b1; drv = 1'b1; wdat = d;
      tick();
      idle();
   endtask

   // Bench drives a pattern; any DUT drive would corrupt it.
   task automatic probe_z(input string tag, input logic [31:0] a, input logic we);
      bus.ABUS = a; bus.WE = we; drv = 1'b1; wdat = 32'h5A5A5A5A;
      #1;
      chk(tag, DBUS, 32'h5A5A5A5A);
      tick();
      idle();
   endtask

   initial begin
      int op;
      idle();
      m_reset();
      // Reset
      rst = 1'b1; key = 4'hF;
      ticks(2);
      rst = 1'b0;
      rd("rst_kdata", BASE, 1, 32'h0);
      rd("rst_kctrl", CTRL, 1, 32'h0);
      chk("rst_intr", {31'b0, INTR}, 32'h0);
      probe_z("z_other", 32'h1000, 1'b0);
      probe_z("z_wr_kdata", BASE, 1'b1);

      // Press accepted after exactly LAT edges
      key[0] = 1'b0;
      bus.ABUS = CTRL; bus.WE = 1'b0;
      for (int n = 1; n <= LAT; n++) begin
         tick();
         chk($sformatf("press_rdy_%0d", n), {31'b0, DBUS[0]}, {31'b0, (n == LAT)});
      end
      idle();
      rd("press_kctrl", CTRL, 1, 32'h1);
      rd("press_kdata", BASE, 1, 32'h1);
      rd("press_clr", CTRL, 1, 32'h0);

      // Release, then bounce on KEY[2]
      key = 4'hF;
      ticks(LAT + 1);
      rd("rel_kdata", BASE, 1, 32'h0);
      key[2] = 1'b0; ticks(3);
      key[2] = 1'b1; tick();
      key[2] = 1'b0; ticks(3);
      key[2] = 1'b1; ticks(LAT + 2);
`ifdef KEY_DEBOUNCE_EN
      rd("bounce_kdata", BASE, 1, 32'h0);
      rd("bounce_kctrl", CTRL, 1, 32'h0);
`else
      rd("bounce_ready", CTRL, 1, 32'h3);
      rd("bounce_kdata", BASE, 1, 32'h0);
`endif
      wr(CTRL, 32'h0);

      // Overrun
      key[1] = 1'b0; ticks(LAT + 1);
      key[1] = 1'b1; ticks(LAT + 1);
      rd("ovr_set", CTRL, 1, 32'h3);
      wr(CTRL, 32'h0);
      rd("ovr_clr", CTRL, 1, 32'h1);
      key[1] = 1'b0; ticks(LAT + 1);
      key[1] = 1'b1; ticks(LAT + 1);
      wr(CTRL, 32'h2);
      rd("ovr_wr1", CTRL, 1, 32'h3);
      rd("ovr_kdata", BASE, 1, 32'h0);
      wr(CTRL, 32'h0);
      rd("ovr_idle", CTRL, 1, 32'h0);

      // Interrupt
      wr(CTRL, 32'h100);
      key[3] = 1'b0;
      ticks(LAT - 1);
      chk("intr_before", {31'b0, INTR}, 32'h0);
      tick();
      chk("intr_set", {31'b0, INTR}, 32'h1);
      rd("intr_kdata", BASE, 1, 32'h8);
      chk("intr_clr", {31'b0, INTR}, 32'h0);
      wr(CTRL, 32'h0);
      key[3] = 1'b1;
      ticks(LAT + 1);

      // KDATA read on the chg edge with ready already set
      key[0] = 1'b0;
      ticks(LAT - 1);
      bus.ABUS = BASE; bus.WE = 1'b0;
      tick();
      idle();
      rd("sim_read", CTRL, 1, 32'h1);
      // KCTRL write of 0 on the chg edge with ready set
      key[0] = 1'b1;
      ticks(LAT - 1);
      wr(CTRL, 32'h0);
      rd("sim_write", CTRL, 1, 32'h3);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(15) == 0) key[i] = ~key[i];
         rst = ($urandom_range(599) == 0);
         op  = int'($urandom_range(7));
         idle();
         case (op)
            2: begin bus.ABUS = BASE; #1; chk("rnd_kdata", DBUS, exp_reg(BASE)); end
            3: begin bus.ABUS = CTRL; #1; chk("rnd_kctrl", DBUS, exp_reg(CTRL)); end
            4: begin
               bus.ABUS = CTRL; bus.WE = 1'b1; drv = 1'b1;
               wdat = $urandom & 32'h0000_0102;
            end
            5: begin bus.ABUS = BASE; bus.WE = 1'b1; drv = 1'b1; wdat = $urandom; end
            6: begin
               bus.ABUS = BASE + 32'd8; drv = 1'b1; wdat = 32'h5A5A5A5A;
               #1; chk("rnd_z", DBUS, 32'h5A5A5A5A);
            end
            default: ;
         endcase
         tick();
      end
      rst = 1'b0;
      idle();
      ticks(2);
      rd("end_kctrl", CTRL, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/key_device.md
# key_device

Memory-mapped pushbutton input device on the processor's shared address/data bus. It is the input counterpart of the LED output device. It synchronises and debounces the four active-low board keys and exposes the pressed state as a readable data register. It also provides a control/status register with ready, overrun and interrupt-enable bits, and raises a level interrupt when a key change is pending and interrupts are enabled.

## Interface
- BITS, 32: bus width for ABUS/DBUS.
- BASE, 32'hF0000010: byte address of KDATA. KCTRL is at BASE+4.
- DEBOUNCE, 16'd50000: consecutive stable cycles required before a key change is accepted. Minimum 1.
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ABUS  input  BITS  bus address.
- DBUS  inout  BITS  bus data; driven only during a read of this device, otherwise high-Z.
- WE  input  1  1 = bus write, 0 = bus read.
- KEY  input  4  raw board keys, active-low (0 = pressed), asynchronous to CLK.
- INTR  output  1  level interrupt request.

## Operation
- **Synchroniser.** Raw KEY passes through two flops (s1 → s2). The stable raw register `stb` follows s2. KDATA = {BITS-4 zeros, ~stb}, so 1 = pressed.
- **Debounce, per key i.** Counter cnt[i], width $clog2(DEBOUNCE)+1.
  - If s2[i]==stb[i], cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE-1, stb[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Net effect: a change is accepted after DEBOUNCE consecutive mismatching cycles. A single-cycle return to match restarts the count.
- **Change event.** `chg` = any stb bit updates on this edge.
- **Address decode.** selD = (ABUS==BASE); selC = (ABUS==BASE+4).
- **Reads** (rd = !WE & sel) drive DBUS combinationally.
  - KDATA read returns {BITS-4 zeros, ~stb}.
  - KCTRL read returns bit0 ready, bit1 overrun, bit8 IE, all other bits 0.
- **ready.**
  - Set on chg.
  - Cleared on an edge where a KDATA read is active and chg is 0.
  - chg and a KDATA read on the same edge: ready stays 1.
- **overrun.**
  - Set on chg while ready is already 1 and no KDATA read is active on that edge.
  - Cleared by a KCTRL write with DBUS[1]=0. Writing 1 has no effect.
  - Set and clear on the same edge: set wins.
- **KCTRL write.** IE <= DBUS[8]. ready is read-only.
- **Ignored accesses.** Writes to KDATA and accesses to any other address have no effect.
- **INTR** = registered (IE & ready), i.e. updated on the same edge as its sources.
- **Reset values.** s1=s2=stb=4'hF (released), cnt=0, ready=0, overrun=0, IE=0, INTR=0, DBUS high-Z.
  - A key held through reset produces a chg after reset deasserts plus the full latency. This is intentional.

## Timing
- KEY edge to KDATA/ready update, debounce compiled in: 2 (sync) + DEBOUNCE cycles, provided the pin is stable throughout.
- Same path, debounce compiled out: 3 cycles.
- ready/overrun/IE update one edge after the causing bus access. INTR follows on the same edge.
- Read data is valid in the same cycle as ABUS/WE, with no wait states.
- Reset mid-debounce discards the count and any pending event.

## Configuration
- KEY_DEBOUNCE_EN defined:
  - Per-key counters present; behaviour as above.
- KEY_DEBOUNCE_EN undefined:
  - Counters and the DEBOUNCE parameter are unused.
  - stb <= s2 every cycle; chg fires on any synchronised change.
  - All register, interrupt and bus behaviour is otherwise identical.

## Test plan
Benches use DEBOUNCE=4.

- **Reset.** Assert reset 2 cycles with KEY=4'hF, then read KDATA and KCTRL → both 0; INTR=0; DBUS=Z when not selected.
- **Press accepted.** KEY[0] falls and is held:
  - KDATA=0x1 and ready=1 exactly 6 cycles after the edge.
  - Read KCTRL → 0x1.
  - Read KDATA → 0x1, and ready=0 next cycle.
- **Bounce rejected.** KEY[2] low 3 cycles, high 1, low 3, then high → KDATA stays 0 and ready stays 0. Without KEY_DEBOUNCE_EN, the same stimulus sets ready.
- **Overrun.** Press KEY[1] (ready=1) without reading, then release it → overrun=1 and KCTRL=0x3.
  - Write KCTRL=0x0 → overrun=0 and IE=0.
  - Write KCTRL=0x2 → overrun is unchanged.
- **Interrupt.** Write KCTRL=0x100, then press KEY[3] → INTR=1 on the same edge ready sets; read KDATA → INTR=0 next cycle.
- **Simultaneous events.**
  - KDATA read coincides with the chg edge → ready=1 and overrun=0 afterwards.
  - A chg edge coincides with a KCTRL write of 0 while ready=1 → overrun=1.
